tx_arbiter: RTL and testbench

- Shares the single UART transmitter (6-bit byte interface, load/ready handshake) between up to NUM_DEV output units, e.g. terminal, line-printer and punch OUT engines.
- Arbitration is round-robin, per record. Once a unit is granted, it owns the line until it flags its last byte, drops its request, or hits the burst limit. This keeps its bytes contiguous on the wire.
- Sits between the per-unit OUT sequencers and the UART TX instance. Exposes per-unit grant for the CPU's busy-test (JBUS) logic.

---
 rtl/tx_arbiter_pkg.sv | 23 ++
 rtl/tx_arbiter_rr_pick.sv | 41 ++++
 rtl/tx_arbiter.sv | 161 ++++++++++++++++
 tb/tb_tx_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// tx_arbiter_pkg
// Shared definitions for the output-unit transmit path: MIX byte width,
// I/O unit numbering and the transmit arbiter state encoding.
// -----------------------------------------------------------------------------
package tx_arbiter_pkg;

    // Width of one MIX character on the serial line.
    localparam int MIX_BYTE_W = 6;

    // I/O unit numbering; also the request/grant bit position on the arbiter.
    localparam int UNIT_TERM  = 0;  // typewriter terminal
    localparam int UNIT_LPR   = 1;  // line printer
    localparam int UNIT_PUNCH = 2;  // card punch

    // Arbiter state encoding.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,  // no owner; pick the next requester
        S_LOCK = 2'd1,  // owner holds the line, waiting to load a byte
        S_GAP  = 2'd2   // one-cycle spacer after each load
    } arb_state_e;

endpackage : tx_arbiter_pkg

// File: rtl/tx_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority selector. Searches upward from
// ptr+1 (wrapping) and returns the first requester found.
//   req     : request vector
//   ptr     : index of the most recently served requester
//   win     : one-hot winner (all zero when no request)
//   win_idx : binary index of the winner (0 when no request)
//   any     : at least one request present
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter  int N  = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic [PW-1:0] win_idx,
    output logic          any
);

    logic [PW-1:0] cand;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that leaves a signal unassigned infers a latch.
    always_comb begin
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        cand    = '0;
        for (int k = 1; k <= N; k++) begin
            cand = PW'((int'(ptr) + k) % N);
            if (!any && req[cand]) begin
                win[cand] = 1'b1;
                win_idx   = cand;
                any       = 1'b1;
            end
        end
    end

endmodule : rr_pick

// File: rtl/tx_arbiter.sv
// -----------------------------------------------------------------------------
// tx_arbiter
// Shares one UART transmitter between NUM_DEV output units. Round-robin,
// per record: a granted unit keeps the line until it flags its last byte,
// drops its request, or reaches MAX_BURST bytes.
//   clk, reset : clock, asynchronous active-low reset
//   req/last/data : per-unit byte request, end-of-record flag, byte bus
//   ack        : one-cycle pulse when the unit's byte is loaded
//   grant      : one-hot current owner (zero when idle)
//   overrun    : sticky, unit was cut off at MAX_BURST without last
//   tx_data/tx_load/tx_ready : transmitter byte interface
//   busy       : any grant active or transmitter not ready
// -----------------------------------------------------------------------------
module tx_arbiter
    import tx_arbiter_pkg::*;
#(
    parameter int NUM_DEV   = 3,
    parameter int BYTE_W    = MIX_BYTE_W,
    parameter int MAX_BURST = 15,
    parameter int CNT_W     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_DEV-1:0]        req,
    input  logic [NUM_DEV-1:0]        last,
    input  logic [NUM_DEV*BYTE_W-1:0] data,
    output logic [NUM_DEV-1:0]        ack,
    output logic [NUM_DEV-1:0]        grant,
    output logic [NUM_DEV-1:0]        overrun,
    output logic [BYTE_W-1:0]         tx_data,
    output logic                      tx_load,
    input  logic                      tx_ready,
    output logic                      busy
);

    localparam int PTR_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;

    arb_state_e          state_q,   state_d;
    logic [NUM_DEV-1:0]  grant_q,   grant_d;
    logic [NUM_DEV-1:0]  overrun_q, overrun_d;
    logic [PTR_W-1:0]    owner_q,   owner_d;
    logic [PTR_W-1:0]    ptr_q,     ptr_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic                last_q,    last_d;
    logic [BYTE_W-1:0]   tx_data_q, tx_data_d;

    logic [NUM_DEV-1:0]  pick_win;
    logic [PTR_W-1:0]    pick_idx;
    logic                pick_any;

    logic                owner_req;
    logic                owner_last;
    logic [BYTE_W-1:0]   owner_data;

    rr_pick #(.N(NUM_DEV)) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .win     (pick_win),
        .win_idx (pick_idx),
        .any     (pick_any)
    );

    assign owner_req  = req[owner_q];
    assign owner_last = last[owner_q];
    assign owner_data = data[int'(owner_q)*BYTE_W +: BYTE_W];

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        overrun_d = overrun_q;
        tx_data_d = tx_data_q;
        ack       = '0;
        tx_load   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_win;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                    last_d  = 1'b0;
                    state_d = S_LOCK;
                end
            end

            S_LOCK: begin
                // A dropped request releases the line even if the transmitter is ready.
                if (!owner_req) begin
                    grant_d = '0;
                    ptr_d   = owner_q;
                    state_d = S_IDLE;
                end else if (tx_ready) begin
                    tx_load   = 1'b1;
                    ack       = grant_q;
                    tx_data_d = owner_data;
                    cnt_d     = cnt_q + CNT_W'(1);
                    last_d    = owner_last;
                    state_d   = S_GAP;
                end
            end

            S_GAP: begin
                // The spacer cycle lets tx_ready fall before another load is considered.
                if (last_q) begin
                    grant_d = '0;
                    ptr_d   = owner_q;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(MAX_BURST)) begin
                    overrun_d[owner_q] = 1'b1;
                    grant_d            = '0;
                    ptr_d              = owner_q;
                    state_d            = S_IDLE;
                end else begin
                    state_d = S_LOCK;
                end
            end

            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            overrun_q <= '0;
            owner_q   <= '0;
            ptr_q     <= PTR_W'(NUM_DEV - 1);
            cnt_q     <= '0;
            last_q    <= 1'b0;
            // NOTE: the held byte is visible on tx_data, so this data register is
            // reset as well to give a defined output straight out of reset.
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            overrun_q <= overrun_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            tx_data_q <= tx_data_d;
        end
    end

    // During a load the fresh byte goes straight out; otherwise the held copy.
    assign tx_data = tx_load ? owner_data : tx_data_q;
    assign grant   = grant_q;
    assign overrun = overrun_q;
    assign busy    = (state_q != S_IDLE) | ~tx_ready;

endmodule : tx_arbiter

// File: tb/tb_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tx_arbiter
// Directed bench for tx_arbiter. Per-unit byte queues drive req/last/data, a
// small transmitter model drives tx_ready, and a transaction-level model of the
// arbitration rules is compared against the DUT outputs on every negedge.
// Directed scenarios add literal expectations on the sequence of loaded bytes.
// -----------------------------------------------------------------------------
module tb_tx_arbiter;

    localparam int NUM_DEV   = 3;
    localparam int BYTE_W    = 6;
    localparam int MAX_BURST = 15;
    localparam int CNT_W     = 4;
    localparam int QD        = 64;

    logic                      clk      = 1'b0;
    logic                      reset    = 1'b0;
    logic [NUM_DEV-1:0]        req      = '0;
    logic [NUM_DEV-1:0]        last     = '0;
    logic [NUM_DEV*BYTE_W-1:0] data     = '0;
    logic                      tx_ready = 1'b1;
    logic [NUM_DEV-1:0]        ack;
    logic [NUM_DEV-1:0]        grant;
    logic [NUM_DEV-1:0]        overrun;
    logic [BYTE_W-1:0]         tx_data;
    logic                      tx_load;
    logic                      busy;

    always #5 clk = ~clk;

    tx_arbiter #(
        .NUM_DEV   (NUM_DEV),
        .BYTE_W    (BYTE_W),
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .last     (last),
        .data     (data),
        .ack      (ack),
        .grant    (grant),
        .overrun  (overrun),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .tx_ready (tx_ready),
        .busy     (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- stimulus: per-unit byte queues + transmitter model -------
    int  q_byte [NUM_DEV][QD];
    bit  q_last [NUM_DEV][QD];
    int  head   [NUM_DEV];
    int  tail   [NUM_DEV];
    int  ack_cnt[NUM_DEV];
    logic [NUM_DEV-1:0] ack_n  = '0;
    logic               load_n = 1'b0;
    int  tx_cnt      = 0;
    int  tx_busy_len = 4;
    bit  tx_hold     = 1'b0;

    always @(negedge clk) begin
        ack_n  = ack;
        load_n = tx_load;
    end

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (ack_n[i] && head[i] < tail[i]) begin
                head[i]++;
                ack_cnt[i]++;
            end
        end
        if (load_n)          tx_cnt = tx_busy_len;
        else if (tx_cnt > 0) tx_cnt--;
        tx_ready = !tx_hold && (tx_cnt == 0);
        for (int i = 0; i < NUM_DEV; i++) begin
            req[i]  = head[i] < tail[i];
            last[i] = req[i] ? q_last[i][head[i]] : 1'b0;
            data[i*BYTE_W +: BYTE_W] = req[i] ? BYTE_W'(q_byte[i][head[i]]) : '0;
        end
    end

    task automatic push(input int u, input int b, input bit l);
        q_byte[u][tail[u]] = b;
        q_last[u][tail[u]] = l;
        tail[u]++;
    endtask

    task automatic clear_q();
        for (int i = 0; i < NUM_DEV; i++) begin
            head[i]    = 0;
            tail[i]    = 0;
            ack_cnt[i] = 0;
        end
    endtask

    function automatic bit q_empty();
        bit e = 1'b1;
        for (int i = 0; i < NUM_DEV; i++) if (head[i] < tail[i]) e = 1'b0;
        return e;
    endfunction

    // ---------------- reference model: rules of the arbiter --------------------
    // m_owner = -1 means nobody owns the line; m_gap marks the spacer after a load.
    int   m_owner = -1;
    int   m_ptr   = NUM_DEV - 1;
    int   m_count = 0;
    bit   m_gap   = 1'b0;
    bit   m_lastf = 1'b0;
    logic [NUM_DEV-1:0] m_over = '0;
    logic [BYTE_W-1:0]  m_txd  = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_owner = -1;
            m_ptr   = NUM_DEV - 1;
            m_count = 0;
            m_gap   = 1'b0;
            m_lastf = 1'b0;
            m_over  = '0;
            m_txd   = '0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= NUM_DEV; k++) begin
                if (m_owner < 0 && req[(m_ptr + k) % NUM_DEV]) m_owner = (m_ptr + k) % NUM_DEV;
            end
            m_count = 0;
            m_gap   = 1'b0;
            m_lastf = 1'b0;
        end else if (m_gap) begin
            m_gap = 1'b0;
            if (m_lastf || m_count == MAX_BURST) begin
                if (!m_lastf) m_over[m_owner] = 1'b1;
                m_ptr   = m_owner;
                m_owner = -1;
            end
        end else if (!req[m_owner]) begin
            m_ptr   = m_owner;
            m_owner = -1;
        end else if (tx_ready) begin
            m_count++;
            m_lastf = last[m_owner];
            m_txd   = data[m_owner*BYTE_W +: BYTE_W];
            m_gap   = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            logic [NUM_DEV-1:0] eg;
            logic [NUM_DEV-1:0] ea;
            logic               el;
            logic [BYTE_W-1:0]  ed;
            logic               eb;
            eg = '0;
            if (m_owner >= 0) eg[m_owner] = 1'b1;
            el = (m_owner >= 0) && !m_gap && req[m_owner] && tx_ready;
            ea = el ? eg : '0;
            ed = el ? data[m_owner*BYTE_W +: BYTE_W] : m_txd;
            eb = (m_owner >= 0) || !tx_ready;
            check("cyc_grant",   grant,   eg);
            check("cyc_ack",     ack,     ea);
            check("cyc_tx_load", tx_load, el);
            check("cyc_tx_data", tx_data, ed);
            check("cyc_overrun", overrun, m_over);
            check("cyc_busy",    busy,    eb);
        end
    end

    // ---------------- load log for directed expectations ----------------------
    logic [NUM_DEV-1:0] log_ack [QD];
    logic [BYTE_W-1:0]  log_data[QD];
    int                 log_n = 0;

    always @(negedge clk) begin
        if (reset && tx_load && log_n < QD) begin
            log_ack[log_n]  = ack;
            log_data[log_n] = tx_data;
            log_n++;
        end
    end

    function automatic logic [NUM_DEV-1:0] onehot(input int u);
        logic [NUM_DEV-1:0] v = '0;
        v[u] = 1'b1;
        return v;
    endfunction

    task automatic wait_idle(input string name, input int max_cyc);
        bit done = 1'b0;
        for (int k = 0; k < max_cyc && !done; k++) begin
            @(negedge clk);
            done = q_empty() && (grant == '0) && !busy;
        end
        check({name, "_idle_reached"}, done, 1'b1);
    endtask

    task automatic wait_load(input string name, input int max_cyc);
        bit done = 1'b0;
        for (int k = 0; k < max_cyc && !done; k++) begin
            @(negedge clk);
            done = tx_load;
        end
        check({name, "_load_seen"}, done, 1'b1);
    endtask

    task automatic apply_reset();
        reset   = 1'b0;
        clear_q();
        tx_cnt  = 0;
        tx_hold = 1'b0;
        repeat (3) @(negedge clk);
        reset   = 1'b1;
        log_n   = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios --------------------------------------
    initial begin
        int e2_u[8];
        int e2_d[8];
        int k;
        e2_u = '{0, 0, 1, 1, 2, 2, 0, 0};
        e2_d = '{'h01, 'h02, 'h11, 'h12, 'h21, 'h22, 'h03, 'h04};
        clear_q();

        // Reset values
        #2;
        check("rst_grant",   grant,   3'b000);
        check("rst_ack",     ack,     3'b000);
        check("rst_tx_load", tx_load, 1'b0);
        check("rst_tx_data", tx_data, 6'h00);
        check("rst_busy",    busy,    1'b0);
        check("rst_overrun", overrun, 3'b000);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Single requester: unit 1, bytes 01..05, transmitter busy 4 clocks per byte
        tx_busy_len = 4;
        @(negedge clk);
        log_n = 0;
        for (int b = 1; b <= 5; b++) push(1, b, b == 5);
        @(negedge clk);
        check("t1_grant_before", grant, 3'b000);
        @(negedge clk);
        check("t1_grant_latency", grant, 3'b010);
        wait_idle("t1", 300);
        check("t1_num_loads", log_n, 5);
        for (int i = 0; i < 5; i++) begin
            check("t1_ack", log_ack[i], 3'b010);
            check("t1_byte", log_data[i], i + 1);
        end
        check("t1_grant_end", grant, 3'b000);

        // Contention: units 0,1,2 with 2-byte records, unit 0 re-requests
        apply_reset();
        tx_busy_len = 2;
        push(0, 'h01, 0); push(0, 'h02, 1);
        push(1, 'h11, 0); push(1, 'h12, 1);
        push(2, 'h21, 0); push(2, 'h22, 1);
        push(0, 'h03, 0); push(0, 'h04, 1);
        wait_idle("t2", 400);
        check("t2_num_loads", log_n, 8);
        for (int i = 0; i < 8; i++) begin
            check("t2_order", log_ack[i], onehot(e2_u[i]));
            check("t2_byte", log_data[i], e2_d[i]);
        end

        // Burst limit: unit 2 streams 20 bytes without last, unit 0 waiting
        log_n = 0;
        tx_busy_len = 1;
        for (int b = 0; b < 20; b++) push(2, 'h20 + b, 0);
        push(0, 'h3f, 1);
        wait_idle("t3", 600);
        check("t3_num_loads", log_n, 21);
        for (int i = 0; i < 15; i++) begin
            check("t3_burst_owner", log_ack[i], 3'b100);
            check("t3_burst_byte", log_data[i], 'h20 + i);
        end
        check("t3_next_owner", log_ack[15], 3'b001);
        check("t3_next_byte", log_data[15], 'h3f);
        for (int i = 16; i < 21; i++) check("t3_tail_owner", log_ack[i], 3'b100);
        check("t3_overrun", overrun, 3'b100);

        // Async reset in the GAP cycle of a record
        log_n = 0;
        tx_busy_len = 0;
        push(1, 'h07, 0); push(1, 'h08, 0); push(1, 'h09, 1);
        wait_load("t6", 50);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("t6_grant",   grant,   3'b000);
        check("t6_ack",     ack,     3'b000);
        check("t6_tx_load", tx_load, 1'b0);
        check("t6_busy",    busy,    1'b0);
        check("t6_overrun", overrun, 3'b000);
        check("t6_tx_data", tx_data, 6'h00);
        clear_q();
        tx_cnt = 0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        log_n = 0;
        push(0, 'h0a, 1); push(1, 'h1a, 1); push(2, 'h2a, 1);
        wait_idle("t6b", 200);
        check("t6_num_loads", log_n, 3);
        check("t6_first", log_ack[0], 3'b001);
        check("t6_second", log_ack[1], 3'b010);
        check("t6_third", log_ack[2], 3'b100);

        // Abandon: unit 0 drops its request after 2 of 5 bytes
        apply_reset();
        tx_busy_len = 4;
        for (int b = 0; b < 5; b++) push(0, 'h30 + b, b == 4);
        k = 0;
        while (ack_cnt[0] < 2 && k < 200) begin
            @(posedge clk);
            #2;
            k++;
        end
        check("t4_two_acks", ack_cnt[0], 2);
        tail[0] = head[0];
        wait_idle("t4", 100);
        check("t4_num_loads", log_n, 2);
        check("t4_grant_end", grant, 3'b000);
        log_n = 0;
        push(0, 'h05, 1); push(1, 'h15, 1);
        wait_idle("t4b", 200);
        check("t4_winner_unit1", log_ack[0], 3'b010);
        check("t4_then_unit0", log_ack[1], 3'b001);

        // Back-pressure: transmitter not ready for 50+ clocks with owner requesting
        log_n = 0;
        tx_hold = 1'b1;
        push(1, 'h2b, 1);
        @(negedge clk);
        @(negedge clk);
        check("t5_grant", grant, 3'b010);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("t5_hold_no_load", tx_load, 1'b0);
            check("t5_hold_grant", grant, 3'b010);
        end
        tx_hold = 1'b0;
        @(negedge clk);
        check("t5_load_on_ready", tx_load, 1'b1);
        check("t5_load_byte", tx_data, 6'h2b);
        check("t5_load_ack", ack, 3'b010);
        wait_idle("t5", 100);
        check("t5_num_loads", log_n, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_tx_arbiter
